// File: rtl/legv8_pkg.sv
// Shared fetch-side types: default widths, fetch FSM states and the buffered fetch entry layout.
package legv8_pkg;

   localparam int unsigned DefaultAddrW  = 64;
   localparam int unsigned DefaultInstrW = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrop,
      StAdv
   } fetch_state_e;

   typedef struct packed {
      logic [DefaultAddrW-1:0]  pc;
      logic [DefaultInstrW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} words for decode; clear wins over push/pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 96,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            push,
   input  logic            pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CntW-1:0]  count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count < CntW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count <= count + CntW'(do_push) - CntW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the instruction at PC over a req/ack memory handshake, buffers it for decode and
// pulses pc_advance once per accepted fetch so the PC block can step to PC+4.
module instr_fetch_unit
   import legv8_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefaultAddrW,
   parameter int unsigned INSTR_W    = DefaultInstrW,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               flush,
   output logic               pc_advance,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               fetch_fault
);

   localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned EntryW = ADDR_W + INSTR_W;

   fetch_state_e      state_q;
   logic [CntW-1:0]   count;
   logic [EntryW-1:0] head;
   logic              push;
   logic              pop;

   assign push        = (state_q == StReq) && imem_ack && !flush;
   assign pop         = instr_valid && instr_ready;
   assign pc_advance  = (state_q == StAdv) && !flush;
   assign instr_valid = (count != '0);
   assign instr_pc    = head[EntryW-1:INSTR_W];
   assign instr       = head[INSTR_W-1:0];

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EntryW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({imem_addr, imem_rdata}),
      .head  (head),
      .count (count)
   );

   // Once a request is raised it stays up until ack; a flush mid-request only marks the data dead.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         fetch_fault <= 1'b0;
      end else begin
         if (flush) begin
            fetch_fault <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (!flush) begin
                  if (pc[1:0] != 2'b00) begin
                     fetch_fault <= 1'b1;
                  end else if (!fetch_fault && (count < CntW'(FIFO_DEPTH))) begin
                     state_q   <= StReq;
                     imem_req  <= 1'b1;
                     imem_addr <= pc;
                  end
               end
            end
            StReq: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state_q  <= flush ? StIdle : StAdv;
               end else if (flush) begin
                  state_q <= StDrop;
               end
            end
            StDrop: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            StAdv: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
